// File: rtl/ctrl_pkg.sv
// Shared types for the X9 ID/EX control stage: opcodes, ALU operations,
// instruction classes and the packed control bundle.
package ctrl_pkg;

    localparam int MCODE_W = 5;
    localparam int ALUOP_W = 4;

    typedef enum logic [MCODE_W-1:0] {
        OP_ADD  = 5'b00000,
        OP_SUB  = 5'b00001,
        OP_ADDI = 5'b00010,
        OP_LB   = 5'b00011,
        OP_SB   = 5'b00100,
        OP_BEQ  = 5'b00101,
        OP_BNE  = 5'b00110,
        OP_NOR  = 5'b00111,
        OP_XOR  = 5'b01000,
        OP_AND  = 5'b01001,
        OP_OR   = 5'b01010,
        OP_SLL  = 5'b01011,
        OP_SLR  = 5'b01100,
        OP_EQ   = 5'b01101,
        OP_LT   = 5'b01110,
        OP_RXOR = 5'b01111
    } opcode_e;

    localparam logic [1:0] OPC_MOVR_PFX = 2'b10;
    localparam logic [1:0] OPC_MOVI_PFX = 2'b11;

    localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALUOP_W-1:0] ALU_ADDI = 4'b0010;
    localparam logic [ALUOP_W-1:0] ALU_LB   = 4'b0011;
    localparam logic [ALUOP_W-1:0] ALU_SB   = 4'b0100;
    localparam logic [ALUOP_W-1:0] ALU_MOVR = 4'b0101;
    localparam logic [ALUOP_W-1:0] ALU_MOVI = 4'b0110;
    localparam logic [ALUOP_W-1:0] ALU_NONE = 4'b1111;

    typedef enum logic [1:0] {
        IT_R    = 2'b00,
        IT_MEM  = 2'b01,
        IT_MOVI = 2'b10,
        IT_MOVR = 2'b11
    } inst_type_e;

    typedef struct packed {
        inst_type_e           inst_type;
        logic                 branch;
        logic                 mem_read;
        logic                 mem_to_reg;
        logic                 mem_write;
        logic                 alu_src;
        logic                 reg_write;
        logic [ALUOP_W-1:0]   alu_op;
    } ctrl_t;

    // Decode default doubles as the bubble pattern; reset clears everything.
    localparam ctrl_t CTRL_DEFAULT = '{
        inst_type:  IT_R,
        branch:     1'b0,
        mem_read:   1'b0,
        mem_to_reg: 1'b0,
        mem_write:  1'b0,
        alu_src:    1'b1,
        reg_write:  1'b1,
        alu_op:     ALU_NONE
    };

    localparam ctrl_t CTRL_RESET = '{
        inst_type:  IT_R,
        branch:     1'b0,
        mem_read:   1'b0,
        mem_to_reg: 1'b0,
        mem_write:  1'b0,
        alu_src:    1'b0,
        reg_write:  1'b0,
        alu_op:     ALU_ADD
    };

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: opcode to control bundle plus which source
// register fields the instruction actually reads.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [MCODE_W-1:0] instr_i,
    output ctrl_t              ctrl_o,
    output logic               reads_a_o,
    output logic               reads_b_o
);

    always_comb begin
        ctrl_o    = CTRL_DEFAULT;
        reads_a_o = 1'b1;
        reads_b_o = 1'b1;

        casez (instr_i)
            OP_ADD:  ctrl_o.alu_op = ALU_ADD;
            OP_SUB:  ctrl_o.alu_op = ALU_SUB;
            OP_ADDI: begin
                ctrl_o.alu_src = 1'b0;
                ctrl_o.alu_op  = ALU_ADDI;
            end
            OP_LB: begin
                ctrl_o.inst_type  = IT_MEM;
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.alu_op     = ALU_LB;
            end
            OP_SB: begin
                ctrl_o.inst_type = IT_MEM;
                ctrl_o.mem_write = 1'b1;
                ctrl_o.reg_write = 1'b0;
                ctrl_o.alu_op    = ALU_SB;
            end
            OP_BEQ, OP_BNE: begin
                ctrl_o.branch    = 1'b1;
                ctrl_o.reg_write = 1'b0;
            end
            OP_NOR, OP_XOR, OP_AND, OP_OR, OP_SLL, OP_SLR:
                ctrl_o.alu_op = instr_i[3:0];
            OP_EQ, OP_LT: begin
                ctrl_o.alu_op    = instr_i[3:0];
                ctrl_o.reg_write = 1'b0;
            end
            OP_RXOR: ctrl_o.alu_op = ALU_NONE;
            {OPC_MOVR_PFX, 3'b???}: begin
                ctrl_o.inst_type = IT_MOVR;
                ctrl_o.alu_op    = ALU_MOVR;
                reads_b_o        = 1'b0;
            end
            {OPC_MOVI_PFX, 3'b???}: begin
                ctrl_o.inst_type = IT_MOVI;
                ctrl_o.alu_op    = ALU_MOVI;
                reads_a_o        = 1'b0;
                reads_b_o        = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_pipe.sv
// ID/EX control stage: decodes one instruction per handshake into a
// registered bundle, with load-use interlock, branch flush and a stall counter.
module control_pipe
    import ctrl_pkg::*;
#(
    parameter int OPWIDTH   = 4,
    parameter int MCODEBITS = 5,
    parameter int RIDX      = 3,
    parameter int CNTW      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MCODEBITS-1:0] instr,
    input  logic [RIDX-1:0]      rs_a,
    input  logic [RIDX-1:0]      rs_b,
    input  logic [RIDX-1:0]      rd,
    input  logic                 flush,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [1:0]           InstType,
    output logic                 BranchInst,
    output logic                 MemRead,
    output logic                 MemtoReg,
    output logic                 MemWrite,
    output logic                 ALUSrc,
    output logic                 RegWrite,
    output logic [OPWIDTH-1:0]   ALUOp,
    output logic [RIDX-1:0]      rd_q,
    output logic [CNTW-1:0]      stall_count
);

    ctrl_t            dec_ctrl;
    logic             reads_a;
    logic             reads_b;

    logic             valid_q, valid_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [RIDX-1:0]  rdst_q, rdst_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic             adv;
    logic             src_match;
    logic             hazard;

    ctrl_decode u_dec (
        .instr_i   (instr),
        .ctrl_o    (dec_ctrl),
        .reads_a_o (reads_a),
        .reads_b_o (reads_b)
    );

    assign adv       = !valid_q || out_ready;
    assign src_match = (reads_a && (rs_a == rdst_q)) || (reads_b && (rs_b == rdst_q));
    // Only a load still sitting in the stage can feed a dependent op too late.
    assign hazard    = valid_q && ctrl_q.mem_read && ctrl_q.reg_write && in_valid && src_match;
    assign in_ready  = (adv && !hazard) || flush;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        rdst_d  = rdst_q;
        cnt_d   = cnt_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (adv && hazard) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_DEFAULT;
            if (cnt_q != '1)
                cnt_d = cnt_q + CNTW'(1);
        end else if (adv && in_valid) begin
            valid_d = 1'b1;
            ctrl_d  = dec_ctrl;
            rdst_d  = rd;
        end else if (adv) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_RESET;
            rdst_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rdst_q  <= rdst_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign InstType    = ctrl_q.inst_type;
    assign BranchInst  = ctrl_q.branch;
    assign MemRead     = ctrl_q.mem_read;
    assign MemtoReg    = ctrl_q.mem_to_reg;
    assign MemWrite    = ctrl_q.mem_write;
    assign ALUSrc      = ctrl_q.alu_src;
    assign RegWrite    = ctrl_q.reg_write;
    assign ALUOp       = OPWIDTH'(ctrl_q.alu_op);
    assign rd_q        = rdst_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_control_pipe.sv
// Scoreboard bench for control_pipe: directed vectors push hand-computed
// bundles; a monitor pops and compares on every output transfer.
module tb_control_pipe;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid, in_ready;
    logic [4:0] instr;
    logic [2:0] rs_a, rs_b, rd;
    logic       flush, out_ready, out_valid;
    logic [1:0] InstType;
    logic       BranchInst, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
    logic [3:0] ALUOp;
    logic [2:0] rd_q;
    logic [15:0] stall_count;

    logic       s_in_ready, s_out_valid;
    logic [1:0] s_InstType;
    logic       s_BranchInst, s_MemRead, s_MemtoReg, s_MemWrite, s_ALUSrc, s_RegWrite;
    logic [3:0] s_ALUOp;
    logic [2:0] s_rd_q;
    logic [1:0] s_stall_count;

    control_pipe u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_a(rs_a), .rs_b(rs_b), .rd(rd), .flush(flush),
        .out_ready(out_ready), .out_valid(out_valid), .InstType(InstType),
        .BranchInst(BranchInst), .MemRead(MemRead), .MemtoReg(MemtoReg),
        .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALUOp(ALUOp),
        .rd_q(rd_q), .stall_count(stall_count)
    );

    // Narrow-counter copy sharing the same stimulus, used for saturation.
    control_pipe #(.CNTW(2)) u_sat (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .instr(instr), .rs_a(rs_a), .rs_b(rs_b), .rd(rd), .flush(flush),
        .out_ready(out_ready), .out_valid(s_out_valid), .InstType(s_InstType),
        .BranchInst(s_BranchInst), .MemRead(s_MemRead), .MemtoReg(s_MemtoReg),
        .MemWrite(s_MemWrite), .ALUSrc(s_ALUSrc), .RegWrite(s_RegWrite), .ALUOp(s_ALUOp),
        .rd_q(s_rd_q), .stall_count(s_stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] e;
        int          c;
        bit          lat1;
    } sb_t;

    sb_t q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [14:0] act_bundle;
    assign act_bundle = {InstType, BranchInst, MemRead, MemtoReg, MemWrite,
                         ALUSrc, RegWrite, ALUOp, rd_q};

    // {InstType, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp, rd}
    function automatic logic [14:0] mk(input logic [1:0] it, input logic [5:0] fl,
                                       input logic [3:0] op, input logic [2:0] r);
        return {it, fl, op, r};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready && !flush) begin
            if (q.size() == 0) begin
                chk("unexpected_bundle", {17'd0, act_bundle}, 32'h7fff_ffff);
            end else begin
                sb_t s;
                s = q.pop_front();
                chk("bundle", {17'd0, act_bundle}, {17'd0, s.e});
                if (s.lat1) chk("latency", cyc - s.c, 1);
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] d, input logic [14:0] e, input int stalls,
                         input bit push, input bit lat1);
        int w;
        bit ok;
        in_valid = 1'b1; instr = op; rs_a = a; rs_b = b; rd = d;
        w = 0; ok = 1'b0;
        while (!ok && w < 20) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else w++;
        end
        chk("stall_cycles", w, stalls);
        if (ok && push) q.push_back('{e, cyc, lat1});
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; instr = '0; rs_a = '0; rs_b = '0; rd = '0;
        flush = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_bundle", {17'd0, act_bundle}, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_count", stall_count, 0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1);
        @(posedge clk); #1;

        // Back-to-back stream, one-cycle latency
        issue(5'b00000, 3'd0, 3'd0, 3'd1, mk(2'b00, 6'b000011, 4'b0000, 3'd1), 0, 1, 1);
        issue(5'b00100, 3'd1, 3'd2, 3'd2, mk(2'b01, 6'b000110, 4'b0100, 3'd2), 0, 1, 1);
        issue(5'b11010, 3'd0, 3'd0, 3'd3, mk(2'b10, 6'b000011, 4'b0110, 3'd3), 0, 1, 1);
        issue(5'b00010, 3'd2, 3'd0, 3'd4, mk(2'b00, 6'b000001, 4'b0010, 3'd4), 0, 1, 1);

        // Load-use on rs_a: one bubble
        issue(5'b00011, 3'd0, 3'd0, 3'd3, mk(2'b01, 6'b011011, 4'b0011, 3'd3), 0, 1, 1);
        issue(5'b00000, 3'd3, 3'd0, 3'd1, mk(2'b00, 6'b000011, 4'b0000, 3'd1), 1, 1, 1);
        idle();
        chk("count_after_1", stall_count, 1);

        // movi reads nothing; movr ignores rs_b
        issue(5'b00011, 3'd0, 3'd0, 3'd3, mk(2'b01, 6'b011011, 4'b0011, 3'd3), 0, 1, 1);
        issue(5'b11010, 3'd3, 3'd3, 3'd2, mk(2'b10, 6'b000011, 4'b0110, 3'd2), 0, 1, 1);
        issue(5'b00011, 3'd0, 3'd0, 3'd5, mk(2'b01, 6'b011011, 4'b0011, 3'd5), 0, 1, 1);
        issue(5'b10011, 3'd1, 3'd5, 3'd6, mk(2'b11, 6'b000011, 4'b0101, 3'd6), 0, 1, 1);

        // Load-use on rs_b
        issue(5'b00011, 3'd0, 3'd0, 3'd5, mk(2'b01, 6'b011011, 4'b0011, 3'd5), 0, 1, 1);
        issue(5'b00001, 3'd0, 3'd5, 3'd7, mk(2'b00, 6'b000011, 4'b0001, 3'd7), 1, 1, 1);

        // Load already drained: no interlock
        issue(5'b00011, 3'd0, 3'd0, 3'd6, mk(2'b01, 6'b011011, 4'b0011, 3'd6), 0, 1, 1);
        idle();
        issue(5'b01001, 3'd6, 3'd6, 3'd1, mk(2'b00, 6'b000011, 4'b1001, 3'd1), 0, 1, 1);
        chk("count_after_2", stall_count, 2);

        // Three more stalls: narrow counter saturates
        for (int i = 0; i < 3; i++) begin
            issue(5'b00011, 3'd0, 3'd0, 3'd2, mk(2'b01, 6'b011011, 4'b0011, 3'd2), 0, 1, 1);
            issue(5'b01101, 3'd2, 3'd1, 3'd4, mk(2'b00, 6'b000010, 4'b1101, 3'd4), 1, 1, 1);
        end
        idle();
        chk("count_after_5", stall_count, 5);
        chk("sat_count", s_stall_count, 3);

        // Backpressure: EX refuses for 3 cycles
        issue(5'b00001, 3'd1, 3'd2, 3'd3, mk(2'b00, 6'b000011, 4'b0001, 3'd3), 0, 1, 0);
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 5'b00101; rs_a = 3'd1; rs_b = 3'd2; rd = 3'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_hold", {16'd0, out_valid, act_bundle}, {16'd0, 1'b1, mk(2'b00, 6'b000011, 4'b0001, 3'd3)});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        issue(5'b00101, 3'd1, 3'd2, 3'd0, mk(2'b00, 6'b100010, 4'b1111, 3'd0), 0, 1, 1);
        issue(5'b01000, 3'd0, 3'd0, 3'd2, mk(2'b00, 6'b000011, 4'b1000, 3'd2), 0, 1, 1);
        idle();

        // Flush wins over a load-use hazard while EX is stalled
        issue(5'b00011, 3'd0, 3'd0, 3'd3, 15'd0, 0, 0, 0);
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 5'b00000; rs_a = 3'd3; rs_b = 3'd0; rd = 3'd1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 1);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("flush_valid", out_valid, 0);
        chk("flush_count", stall_count, 5);
        @(posedge clk); #1;
        issue(5'b01111, 3'd4, 3'd4, 3'd5, mk(2'b00, 6'b000011, 4'b1111, 3'd5), 0, 1, 1);
        idle();
        idle();
        chk("queue_drained", q.size(), 0);

        // Asynchronous reset with a valid bundle held
        out_ready = 1'b0;
        issue(5'b01000, 3'd0, 3'd0, 3'd7, 15'd0, 0, 0, 0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", out_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_bundle", {17'd0, act_bundle}, 0);
        chk("midrst_count", stall_count, 0);
        chk("midrst_sat", s_stall_count, 0);
        @(negedge clk) reset_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("midrst_ready", in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control_pipe.md
# control_pipe

Registered, hazard-aware successor to the combinational control decoder for the X9 core. Sits between fetch and execute: accepts one opcode plus register indices per cycle over a valid/ready handshake, decodes it, and presents the control bundle from an ID/EX pipeline register. Adds a load-use interlock that inserts bubbles, branch flush, and a saturating stall counter.

## Interface
- OPWIDTH, 4, ALUOp width
- MCODEBITS, 5, opcode width
- RIDX, 3, register-index width
- CNTW, 16, stall-counter width
- clk  input  1  clock
- reset_n  input  1  reset; one clock; reset is asynchronous and active-low
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  instruction accepted this cycle
- instr  input  MCODEBITS  opcode
- rs_a, rs_b, rd  input  RIDX each  source/destination indices
- flush  input  1  branch taken in EX; squash
- out_ready  input  1  EX can take the bundle
- out_valid  output  1  bundle valid
- InstType  output  2; BranchInst, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite  output  1 each; ALUOp  output  OPWIDTH
- rd_q  output  RIDX  registered destination
- stall_count  output  CNTW  bubbles inserted, saturating

## Operation
- Defaults: InstType 00, ALUSrc 1, RegWrite 1, ALUOp 1111, all other flags 0.
- Decode:
  - 00000 add ALUOp 0000; 00001 sub 0001.
  - 00010 addi: ALUSrc 0, ALUOp 0010.
  - 00011 lb: InstType 01, MemRead 1, MemtoReg 1, ALUOp 0011.
  - 00100 sb: InstType 01, MemWrite 1, RegWrite 0, ALUOp 0100.
  - 00101 beq / 00110 bne: BranchInst 1, RegWrite 0, ALUOp default.
  - 00111–01100 (nor, xor, and, or, sll, slr): ALUOp = instr[3:0].
  - 01101 eq / 01110 lt: ALUOp = instr[3:0], RegWrite 0.
  - 01111 rxor: ALUOp 1111.
  - 10xxx movr: InstType 11, ALUOp 0101.
  - 11xxx movi: InstType 10, ALUOp 0110.
- Source use: movi reads no register; movr reads rs_a only; all other opcodes read rs_a and rs_b.
- Hazard: raised when out_valid & MemRead (registered) & RegWrite (registered) & in_valid & the incoming instruction reads a register equal to rd_q.
- Advance condition: adv = !out_valid | out_ready.
- in_ready = adv & !hazard, or flush = 1.
- Register-update priority, applied on each clock:
  1. flush: out_valid←0; input dropped even though in_ready = 1.
  2. adv & hazard: load a bubble (out_valid←0, flags at defaults), hold the input, stall_count += 1 (saturating at all-ones).
  3. adv & in_valid: load the decoded bundle and rd, out_valid←1.
  4. adv & !in_valid: out_valid←0.
  5. !adv: hold all registered outputs.
- A bubble lasts exactly one cycle; the next cycle the hazard clears because the registered bundle is no longer lb.

## Timing
- Latency: 1 cycle, acceptance to out_valid.
- Throughput: 1 instruction/cycle with no hazards.
- Reset (asynchronous, any cycle including mid-stall):
  - out_valid, all flags, InstType, rd_q, stall_count go to 0; ALUOp goes to 0000.
  - in_ready is 1 while in_valid = 0 after reset deasserts.
- in_ready is combinational from in_valid, instr, rs_a, rs_b, flush, out_ready and the stage registers.
- Registered outputs change only on clk or reset; they are stable while out_valid & !out_ready.
- Simultaneous events:
  - flush with hazard: flush wins, no count.
  - flush with out_ready = 0: bundle is still squashed.
- stall_count holds at 2^CNTW−1 once saturated.

## Structure
- Package ctrl_pkg holds:
  - opcode constants/enum (5-bit);
  - ALUOp constants;
  - InstType enum (R=00, MEM=01, MOVI=10, MOVR=11);
  - packed struct ctrl_t for the flag bundle, with its default value.
- Sub-module ctrl_decode: purely combinational; instr → ctrl_t plus reads_a/reads_b.
- control_pipe owns the stage register, interlock, flush and counter.

## Test plan
- Reset mid-stream with out_valid = 1 → all outputs 0 immediately; stall_count = 0.
- Stream add, sb, movi 11010, addi with out_ready = 1 → one bundle per cycle, one-cycle latency. sb gives RegWrite 0, MemWrite 1, ALUOp 0100. movi gives InstType 10, ALUOp 0110.
- lb rd = 3, then add rs_a = 3 → one bubble, in_ready low one cycle, add emitted next cycle, stall_count = 1. Repeat with movi → no bubble.
- out_ready held 0 for 3 cycles with in_valid = 1 → in_ready = 0 and bundle unchanged for those cycles; resumes with no loss or duplication.
- flush asserted together with an lb-hazard → out_valid 0 next cycle, stall_count unchanged, input dropped.
- CNTW = 2, force 5 load-use stalls → stall_count saturates at 3.
